// File: rtl/fnn_pkg.sv
//------------------------------------------------------------------------------
// Module   : fnn_pkg
// Brief    : Shared constants, FSM state type and sign-extension helper for
//            the FNN neuron accumulator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fnn_pkg;

    localparam int c_SUM_W_DEFAULT = 3;
    localparam int c_ACC_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } fnn_state_t;

    // Treats the low 'width' bits of val as signed and extends them to 32 bits.
    function automatic logic signed [31:0] sext_to32(input logic [31:0] val, input int width);
        logic [31:0] shifted;
        shifted = val << (32 - width);
        return $signed(shifted) >>> (32 - width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fnn_sat_add.sv
//------------------------------------------------------------------------------
// Module   : fnn_sat_add
// Brief    : ACC_W-bit signed adder; saturating when FNN_ACC_SATURATE_EN is
//            defined, two's-complement wrap-around otherwise.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fnn_sat_add #(
    parameter int ACC_W = 8
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum
);

    logic signed [ACC_W-1:0] w_raw;

    assign w_raw = i_a + i_b;

`ifdef FNN_ACC_SATURATE_EN
    logic w_ovf;

    // Overflow only when both operands share a sign the result lacks.
    assign w_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

    always_comb begin
        o_sum = w_raw;
        if (w_ovf) begin
            o_sum = i_a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign o_sum = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/fnn_neuron_accumulator.sv
//------------------------------------------------------------------------------
// Module   : fnn_neuron_accumulator
// Brief    : Accumulates N_STEPS signed partial sums into a neuron
//            pre-activation and thresholds it; FNN_ACC_SATURATE_EN selects
//            saturating accumulation.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fnn_neuron_accumulator
    import fnn_pkg::*;
#(
    parameter int SUM_W   = c_SUM_W_DEFAULT,
    parameter int ACC_W   = c_ACC_W_DEFAULT,
    parameter int N_STEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic [ACC_W-1:0] in_thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_act,
    output logic [ACC_W-1:0] out_acc
);

    localparam int                  c_STEP_W    = $clog2(N_STEPS + 1);
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(N_STEPS - 1);

    fnn_state_t              r_state;
    fnn_state_t              w_state_next;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_thr;
    logic [c_STEP_W-1:0]     r_step;
    logic signed [ACC_W-1:0] w_sum_ext;
    logic signed [ACC_W-1:0] w_add_a;
    logic signed [ACC_W-1:0] w_acc_next;
    logic                    w_in_beat;
    logic                    w_out_beat;

    assign in_ready   = (r_state != DONE);
    assign out_valid  = (r_state == DONE);
    assign w_in_beat  = in_valid && in_ready;
    assign w_out_beat = out_valid && out_ready;

    assign w_sum_ext = ACC_W'(sext_to32(32'(in_sum), SUM_W));
    // The first beat of a neuron starts from zero, so the adder path is shared.
    assign w_add_a   = (r_state == IDLE) ? '0 : r_acc;

    fnn_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_a   (w_add_a),
        .i_b   (w_sum_ext),
        .o_sum (w_acc_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_in_beat) w_state_next = (N_STEPS == 1) ? DONE : ACCUM;
            ACCUM:   if (w_in_beat && (r_step == c_LAST_STEP)) w_state_next = DONE;
            DONE:    if (w_out_beat) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_thr   <= '0;
            r_step  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_in_beat) begin
                r_acc  <= w_acc_next;
                r_step <= (r_state == IDLE) ? c_STEP_W'(1) : r_step + 1'b1;
                if (r_state == IDLE) begin
                    r_thr <= in_thr;
                end
            end else if (w_out_beat) begin
                r_acc  <= '0;
                r_step <= '0;
            end
        end
    end

    assign out_acc = out_valid ? r_acc : '0;
    assign out_act = out_valid && (r_acc >= r_thr);

endmodule

`default_nettype wire

// File: tb/tb_fnn_neuron_accumulator.sv
//------------------------------------------------------------------------------
// Module   : tb_fnn_neuron_accumulator
// Brief    : Self-checking bench for fnn_neuron_accumulator (default, narrow
//            ACC_W=4/N_STEPS=8 and N_STEPS=1 instances).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fnn_neuron_accumulator;

`ifdef FNN_ACC_SATURATE_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] vld;
    logic [2:0] sum_s;
    logic [7:0] thr_s;
    logic       ordy;
    int         sel;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       rdy_a, ov_a, act_a;
    logic [7:0] acc_a;
    logic       rdy_b, ov_b, act_b;
    logic [3:0] acc_b;
    logic       rdy_c, ov_c, act_c;
    logic [7:0] acc_c;

    logic              obs_valid, obs_ready, obs_act;
    logic signed [31:0] obs_acc;

    always #5 clk = ~clk;

    fnn_neuron_accumulator #(.SUM_W(3), .ACC_W(8), .N_STEPS(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy_a), .in_sum(sum_s),
        .in_thr(thr_s), .out_valid(ov_a), .out_ready(ordy), .out_act(act_a), .out_acc(acc_a));

    fnn_neuron_accumulator #(.SUM_W(3), .ACC_W(4), .N_STEPS(8)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy_b), .in_sum(sum_s),
        .in_thr(thr_s[3:0]), .out_valid(ov_b), .out_ready(ordy), .out_act(act_b), .out_acc(acc_b));

    fnn_neuron_accumulator #(.SUM_W(3), .ACC_W(8), .N_STEPS(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy_c), .in_sum(sum_s),
        .in_thr(thr_s), .out_valid(ov_c), .out_ready(ordy), .out_act(act_c), .out_acc(acc_c));

    always_comb begin
        obs_valid = ov_a;
        obs_ready = rdy_a;
        obs_act   = act_a;
        obs_acc   = {{24{acc_a[7]}}, acc_a};
        if (sel == 1) begin
            obs_valid = ov_b;
            obs_ready = rdy_b;
            obs_act   = act_b;
            obs_acc   = {{28{acc_b[3]}}, acc_b};
        end else if (sel == 2) begin
            obs_valid = ov_c;
            obs_ready = rdy_c;
            obs_act   = act_c;
            obs_acc   = {{24{acc_c[7]}}, acc_c};
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: sum all partial sums in plain integers, then wrap or clamp each step.
    function automatic int model_acc(input int sums[$], input int w, input bit sat);
        int acc = 0;
        int lo  = -(1 << (w - 1));
        int hi  = (1 << (w - 1)) - 1;
        foreach (sums[i]) begin
            acc += sums[i];
            if (sat) begin
                if (acc > hi) acc = hi;
                if (acc < lo) acc = lo;
            end else begin
                while (acc > hi) acc -= (1 << w);
                while (acc < lo) acc += (1 << w);
            end
        end
        return acc;
    endfunction

    // Sends one neuron's worth of beats on the selected DUT, then checks and drains the result.
    task automatic run(input int sums[$], input int thr, input int gaps[$], input int hold, input string tag);
        int w;
        int exp_acc;
        int g;
        logic exp_act;
        w = (sel == 1) ? 4 : 8;
        for (int i = 0; i < sums.size(); i++) begin
            g = (i < gaps.size() && i != sums.size() - 1) ? gaps[i] : 0;
            sum_s = 3'(sums[i]);
            thr_s = (i == 0) ? 8'(thr) : 8'($urandom_range(0, 255));
            vld[sel] = 1'b1;
            chk({tag, "_pre_valid"}, 32'(obs_valid), 0);
            chk({tag, "_pre_ready"}, 32'(obs_ready), 1);
            @(negedge clk);
            vld = '0;
            for (int k = 0; k < g; k++) begin
                thr_s = 8'($urandom_range(0, 255));
                @(negedge clk);
            end
        end
        exp_acc = model_acc(sums, w, c_SAT);
        exp_act = (exp_acc >= thr);
        for (int h = 0; h <= hold; h++) begin
            chk({tag, "_out_valid"}, 32'(obs_valid), 1);
            chk({tag, "_out_acc"}, obs_acc, exp_acc);
            chk({tag, "_out_act"}, 32'(obs_act), 32'(exp_act));
            chk({tag, "_busy_ready"}, 32'(obs_ready), 0);
            if (h < hold) @(negedge clk);
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk({tag, "_drained_valid"}, 32'(obs_valid), 0);
        chk({tag, "_drained_ready"}, 32'(obs_ready), 1);
    endtask

    initial begin
        int sq[$];
        int gq[$];
        int n;

        rst   = 1'b1;
        vld   = '0;
        sum_s = '0;
        thr_s = '0;
        ordy  = 1'b0;
        sel   = 0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #0;
            chk("reset_valid", 32'(obs_valid), 0);
            chk("reset_ready", 32'(obs_ready), 1);
            chk("reset_acc", obs_acc, 0);
            chk("reset_act", 32'(obs_act), 0);
        end
        rst = 1'b0;
        sel = 0;
        @(negedge clk);

        sq = {2, 1, -1, 2};  gq = {0, 0, 0};
        run(sq, 2, gq, 0, "b2b_pos");
        sq = {-1, -2, 0, 1}; gq = {0, 0, 0};
        run(sq, 0, gq, 5, "stall_neg");
        sq = {2, -2, 1, 2};  gq = {0, 0, 0};
        run(sq, 3, gq, 0, "gap_ref");
        gq = {2, 0, 4};
        run(sq, 3, gq, 1, "gapped");

        for (int r = 0; r < 6; r++) begin
            sq.delete();
            gq.delete();
            for (int i = 0; i < 4; i++) begin
                sq.push_back(int'($urandom_range(0, 4)) - 2);
                gq.push_back(int'($urandom_range(0, 2)));
            end
            run(sq, int'($urandom_range(0, 8)) - 4, gq, int'($urandom_range(0, 3)), "rand_a");
        end

        sel = 1;
        sq.delete();
        gq.delete();
        for (int i = 0; i < 8; i++) sq.push_back(2);
        run(sq, 0, gq, 0, "narrow_all_pos");
        sq.delete();
        for (int i = 0; i < 8; i++) sq.push_back(-2);
        run(sq, -1, gq, 0, "narrow_all_neg");
        for (int r = 0; r < 2; r++) begin
            sq.delete();
            for (int i = 0; i < 8; i++) sq.push_back(int'($urandom_range(0, 4)) - 2);
            run(sq, int'($urandom_range(0, 8)) - 4, gq, 0, "rand_b");
        end

        sel = 2;
        for (int r = 0; r < 5; r++) begin
            n = int'($urandom_range(0, 4)) - 2;
            sq = {n};
            run(sq, int'($urandom_range(0, 4)) - 2, gq, 0, "single_step");
        end

        sel = 0;
        vld[0] = 1'b1;
        sum_s  = 3'd2;
        thr_s  = 8'd1;
        @(negedge clk);
        sum_s  = 3'd2;
        @(negedge clk);
        vld = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(obs_valid), 0);
        chk("midrst_ready", 32'(obs_ready), 1);
        chk("midrst_acc", obs_acc, 0);
        chk("midrst_act", 32'(obs_act), 0);
        rst = 1'b0;
        @(negedge clk);
        sq = {-1, 1, -2, 1}; gq = {0, 0, 0};
        run(sq, -1, gq, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fnn_neuron_accumulator.md
# fnn_neuron_accumulator

Downstream stage of the ternary synapse array. Consumes a stream of small signed partial sums, each the sum of one group of synapse products, and accumulates N_STEPS of them into one neuron pre-activation. Compares the result against a per-neuron threshold and emits a 1-bit activation, which becomes the binary `x` input of the next layer. A valid/ready handshake sits on both sides, so the synapse array can be time-multiplexed across input groups.

## Interface
Parameters:
- SUM_W, 3, width of the incoming signed partial sum (two-synapse group gives -2..+2)
- ACC_W, 8, width of the signed accumulator and threshold
- N_STEPS, 4, partial sums per neuron; must be ≥1

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  partial sum present
- in_ready  out  1  block can accept a partial sum
- in_sum  in  SUM_W  signed partial sum
- in_thr  in  ACC_W  signed threshold; sampled only on the first beat of a neuron
- out_valid  out  1  neuron result present
- out_ready  in  1  consumer accepts result
- out_act  out  1  activation: 1 iff acc ≥ thr (signed compare)
- out_acc  out  ACC_W  final signed accumulator value

## Operation
- FSM states: IDLE, ACCUM, DONE.
- Input beat: `in_valid && in_ready`.
- `in_ready = (state != DONE)`.
- IDLE, on beat:
  - acc ← sext(in_sum); thr_q ← in_thr; step ← 1.
  - Go to DONE if N_STEPS==1, else ACCUM.
- ACCUM, on beat:
  - acc ← acc + sext(in_sum); step ← step+1.
  - Go to DONE when step == N_STEPS-1 (the N-th beat).
- No beat: hold all state.
- DONE:
  - out_valid=1; out_acc=acc; out_act=(acc ≥ thr_q).
  - Outputs stable while out_valid && !out_ready.
  - On `out_valid && out_ready`, return to IDLE. acc and step clear.
- Arithmetic: in_sum sign-extended to ACC_W. Overflow handling is set by the configuration macro. Compare is signed, full ACC_W.
- in_thr changes after the first beat are ignored for that neuron.
- Reset mid-neuron discards the partial accumulation. No output is produced.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_act=0, out_acc=0, acc=0, step=0, thr_q=0.
- Latency: out_valid rises the cycle after the N-th accepted beat.
- Throughput: one neuron per N_STEPS+1 cycles minimum. In DONE, in_ready=0, so there is no overlap of output hold and the next neuron's first beat.
- in_valid gaps stall accumulation without loss.
- out_ready held low stalls indefinitely. The upstream sees in_ready=0.
- rst has priority over every handshake in the same cycle.
- Step counter width: $clog2(N_STEPS+1).

## Configuration
- `FNN_ACC_SATURATE_EN` defined:
  - Each addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Once saturated, the value moves back only through subsequent opposite-sign sums.
- Undefined: two's-complement wrap-around at ACC_W bits.

## Structure
- Shared package `fnn_pkg` holds:
  - default SUM_W/ACC_W constants;
  - the FSM state enum type (IDLE, ACCUM, DONE);
  - a signed sign-extension helper function.
- Sub-module `fnn_sat_add`:
  - ACC_W-bit signed adder;
  - saturating under `FNN_ACC_SATURATE_EN`, plain add otherwise;
  - instantiated once for the accumulator update.

## Test plan
- Defaults, thr=2, sums +2,+1,-1,+2 on consecutive cycles → out_valid the next cycle, out_acc=4, out_act=1.
- thr=0, sums -1,-2,0,+1 → out_acc=-2, out_act=0. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0 throughout.
- in_valid gaps (beats on cycles 0,3,4,9) → result is identical to back-to-back input. Change in_thr after beat 0 → no effect.
- ACC_W=4, N_STEPS=8, all +2:
  - with `FNN_ACC_SATURATE_EN`: out_acc=7;
  - without it: out_acc=0 (wrapped).
- N_STEPS=1: each beat produces one result. Assert rst after 2 beats of an N_STEPS=4 neuron → all outputs reset, and the next 4 beats form a fresh neuron.
